fetch_ctrl: RTL and testbench

Sequencing controller for the fetch stage of the 5-stage pipelined CPU. It decides every cycle whether the PC advances and which next-PC source is used: PC+4, the PC-relative branch target, or the BR register target. It also decides whether the IF/ID register holds, loads or is flushed to a NOP. It handles post-reset hold, load-use stalls, taken-branch flushes and a halt/resume handshake, and keeps saturating stall and flush counters.

---
 rtl/fetch_ctrl.sv | 189 ++++++++++++++++++
 tb/tb_fetch_ctrl.sv | 248 ++++++++++++++++++++++++
 2 files changed

// File: rtl/fetch_ctrl.sv
// ---------------------------------------------------------------------------
// fetch_ctrl
//
// Fetch-stage sequencing controller for the 5-stage pipeline. Every cycle it
// decides whether the PC advances and from which source (PC+4, PC-relative
// branch target, or BR register target). It also decides whether IF/ID holds,
// loads the fetched opcode or loads a NOP, and whether ID/EX takes a bubble.
//
// Ports
//   clk            in   system clock, all state changes on the rising edge
//   reset          in   synchronous active-high reset
//   loadUseHazard  in   ID needs a load result that is still in EX
//   BrTaken        in   ID resolved a taken PC-relative branch
//   BRBranch       in   ID resolved a BR (register) branch
//   halt           in   level request to stop fetching
//   resume         in   request to leave HALTED (honoured only with halt low)
//   pcWrite        out  PC register write enable
//   pcSel          out  next-PC select: 00 PC+4, 01 IncrBr, 10 Db
//   ifidWrite      out  IF/ID load enable
//   ifidFlush      out  IF/ID loads an all-zero NOP instead of the opcode
//   idexBubble     out  ID/EX captures zeroed control this edge
//   fsmState       out  00 HOLD, 01 RUN, 10 HALTED (registered)
//   stallCount     out  saturating count of load-use stall cycles
//   flushCount     out  saturating count of taken-branch flushes
//
// Halt/resume handshake: halt is a level. In RUN with no stall or branch
// being served, halt=1 moves to HALTED on the next edge while the current
// fetch is discarded (IF/ID flushed, PC held) so that it is refetched later.
// HALTED is left on the edge after a cycle with resume=1 and halt=0; the
// resume cycle itself still drives HALTED outputs.
//
// All control outputs are Mealy: combinational from state and inputs.
// ---------------------------------------------------------------------------
module fetch_ctrl #(
    parameter int RESET_HOLD_CYCLES = 2
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        loadUseHazard,
    input  logic        BrTaken,
    input  logic        BRBranch,
    input  logic        halt,
    input  logic        resume,
    output logic        pcWrite,
    output logic [1:0]  pcSel,
    output logic        ifidWrite,
    output logic        ifidFlush,
    output logic        idexBubble,
    output logic [1:0]  fsmState,
    output logic [31:0] stallCount,
    output logic [31:0] flushCount
);

    typedef enum logic [1:0] {
        ST_HOLD   = 2'b00,
        ST_RUN    = 2'b01,
        ST_HALTED = 2'b10
    } state_e;

    localparam logic [1:0] SEL_PC4  = 2'b00;
    localparam logic [1:0] SEL_INCR = 2'b01;
    localparam logic [1:0] SEL_DB   = 2'b10;

    // Last holdCnt value spent in HOLD before moving to RUN.
    localparam logic [7:0] HOLD_LAST = 8'(RESET_HOLD_CYCLES - 1);

    state_e      state_q, state_d;
    logic [7:0]  hold_cnt_q, hold_cnt_d;
    logic [31:0] stall_cnt_q, stall_cnt_d;
    logic [31:0] flush_cnt_q, flush_cnt_d;

    // Event strobes produced by the RUN decode, consumed by the counters.
    logic stall_evt;
    logic flush_evt;

    // -----------------------------------------------------------------------
    // State register
    // -----------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= ST_HOLD;
            hold_cnt_q  <= 8'd0;
            stall_cnt_q <= 32'd0;
            flush_cnt_q <= 32'd0;
        end else begin
            state_q     <= state_d;
            hold_cnt_q  <= hold_cnt_d;
            stall_cnt_q <= stall_cnt_d;
            flush_cnt_q <= flush_cnt_d;
        end
    end

    // -----------------------------------------------------------------------
    // Next-state and Mealy outputs
    // -----------------------------------------------------------------------
    always_comb begin
        // Defaults: normal sequential fetch, stay in current state.
        state_d    = state_q;
        hold_cnt_d = hold_cnt_q;
        pcWrite    = 1'b1;
        pcSel      = SEL_PC4;
        ifidWrite  = 1'b1;
        ifidFlush  = 1'b0;
        idexBubble = 1'b0;
        stall_evt  = 1'b0;
        flush_evt  = 1'b0;

        unique case (state_q)
            ST_HOLD: begin
                pcWrite    = 1'b0;
                ifidFlush  = 1'b1;
                idexBubble = 1'b1;
                hold_cnt_d = hold_cnt_q + 8'd1;
                if (hold_cnt_q == HOLD_LAST) begin
                    state_d = ST_RUN;
                end
            end

            ST_RUN: begin
                if (loadUseHazard) begin
                    // Branch operands are stale while the load is pending,
                    // so branches are deferred until the hazard clears.
                    pcWrite    = 1'b0;
                    ifidWrite  = 1'b0;
                    idexBubble = 1'b1;
                    stall_evt  = 1'b1;
                end else if (BRBranch) begin
                    pcSel     = SEL_DB;
                    ifidFlush = 1'b1;
                    flush_evt = 1'b1;
                end else if (BrTaken) begin
                    pcSel     = SEL_INCR;
                    ifidFlush = 1'b1;
                    flush_evt = 1'b1;
                end else if (halt) begin
                    // PC is held so the discarded fetch is redone on resume.
                    pcWrite   = 1'b0;
                    ifidFlush = 1'b1;
                    state_d   = ST_HALTED;
                end
            end

            ST_HALTED: begin
                pcWrite   = 1'b0;
                ifidFlush = 1'b1;
                if (resume && !halt) begin
                    state_d = ST_RUN;
                end
            end

            default: begin
                // Unreachable encoding: behave like HOLD and recover.
                pcWrite    = 1'b0;
                ifidFlush  = 1'b1;
                idexBubble = 1'b1;
                state_d    = ST_HOLD;
                hold_cnt_d = 8'd0;
            end
        endcase

        // Reset overrides whatever the current state would drive.
        if (reset) begin
            pcWrite    = 1'b0;
            pcSel      = SEL_PC4;
            ifidWrite  = 1'b1;
            ifidFlush  = 1'b1;
            idexBubble = 1'b1;
        end
    end

    // -----------------------------------------------------------------------
    // Saturating event counters
    // -----------------------------------------------------------------------
    always_comb begin
        stall_cnt_d = stall_cnt_q;
        flush_cnt_d = flush_cnt_q;
        if (stall_evt && (stall_cnt_q != 32'hFFFF_FFFF)) begin
            stall_cnt_d = stall_cnt_q + 32'd1;
        end
        if (flush_evt && (flush_cnt_q != 32'hFFFF_FFFF)) begin
            flush_cnt_d = flush_cnt_q + 32'd1;
        end
    end

    assign fsmState   = state_q;
    assign stallCount = stall_cnt_q;
    assign flushCount = flush_cnt_q;

endmodule

// File: tb/tb_fetch_ctrl.sv
// ---------------------------------------------------------------------------
// tb_fetch_ctrl
//
// Directed bench for fetch_ctrl with RESET_HOLD_CYCLES=2. Inputs change just
// after each falling edge; outputs are sampled 1 ns later, well away from the
// rising edge. Control outputs are compared as one packed vector
// {pcWrite, pcSel[1:0], ifidWrite, ifidFlush, idexBubble}.
// ---------------------------------------------------------------------------
module tb_fetch_ctrl;

    logic        clk;
    logic        reset;
    logic        loadUseHazard;
    logic        BrTaken;
    logic        BRBranch;
    logic        halt;
    logic        resume;
    logic        pcWrite;
    logic [1:0]  pcSel;
    logic        ifidWrite;
    logic        ifidFlush;
    logic        idexBubble;
    logic [1:0]  fsmState;
    logic [31:0] stallCount;
    logic [31:0] flushCount;

    int n_vec;
    int n_err;

    // Expected control vectors {pcWrite, pcSel, ifidWrite, ifidFlush, idexBubble}
    localparam logic [5:0] O_HOLD   = 6'b0_00_1_1_1;  // reset / HOLD
    localparam logic [5:0] O_NORM   = 6'b1_00_1_0_0;  // sequential fetch
    localparam logic [5:0] O_STALL  = 6'b0_00_0_0_1;  // load-use stall
    localparam logic [5:0] O_BR     = 6'b1_10_1_1_0;  // BR register branch
    localparam logic [5:0] O_BTAKEN = 6'b1_01_1_1_0;  // PC-relative branch
    localparam logic [5:0] O_HALT   = 6'b0_00_1_1_0;  // halt request / HALTED

    localparam logic [1:0] S_HOLD   = 2'b00;
    localparam logic [1:0] S_RUN    = 2'b01;
    localparam logic [1:0] S_HALTED = 2'b10;

    fetch_ctrl #(.RESET_HOLD_CYCLES(2)) dut (
        .clk           (clk),
        .reset         (reset),
        .loadUseHazard (loadUseHazard),
        .BrTaken       (BrTaken),
        .BRBranch      (BRBranch),
        .halt          (halt),
        .resume        (resume),
        .pcWrite       (pcWrite),
        .pcSel         (pcSel),
        .ifidWrite     (ifidWrite),
        .ifidFlush     (ifidFlush),
        .idexBubble    (idexBubble),
        .fsmState      (fsmState),
        .stallCount    (stallCount),
        .flushCount    (flushCount)
    );

    // ---------------- clock ----------------
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // ---------------- driver tasks ----------------
    // Advance to the next falling edge and apply one input vector.
    task automatic drive(input logic rst, input logic luh, input logic bt,
                         input logic brb, input logic hlt, input logic rsm);
        @(negedge clk);
        reset         = rst;
        loadUseHazard = luh;
        BrTaken       = bt;
        BRBranch      = brb;
        halt          = hlt;
        resume        = rsm;
        #1;
    endtask

    // ---------------- checkers ----------------
    task automatic chk_outs(input string tag, input logic [5:0] exp);
        logic [5:0] obs;
        obs = {pcWrite, pcSel, ifidWrite, ifidFlush, idexBubble};
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s ctrl: observed %b expected %b", tag, obs, exp);
        end
    endtask

    task automatic chk_state(input string tag, input logic [1:0] exp);
        n_vec++;
        assert (fsmState === exp) else begin
            n_err++;
            $error("FAIL %s state: observed %b expected %b", tag, fsmState, exp);
        end
    endtask

    task automatic chk_cnt(input string tag, input logic [31:0] exp_stall,
                           input logic [31:0] exp_flush);
        n_vec++;
        assert (stallCount === exp_stall) else begin
            n_err++;
            $error("FAIL %s stallCount: observed %h expected %h", tag, stallCount, exp_stall);
        end
        n_vec++;
        assert (flushCount === exp_flush) else begin
            n_err++;
            $error("FAIL %s flushCount: observed %h expected %h", tag, flushCount, exp_flush);
        end
    endtask

    // ---------------- directed sequence ----------------
    initial begin
        n_vec         = 0;
        n_err         = 0;
        reset         = 1'b1;
        loadUseHazard = 1'b0;
        BrTaken       = 1'b0;
        BRBranch      = 1'b0;
        halt          = 1'b0;
        resume        = 1'b0;

        // Reset held: outputs forced, then state/counters cleared.
        drive(1, 0, 0, 0, 0, 0);
        chk_outs("rst_force", O_HOLD);
        drive(1, 0, 0, 0, 0, 0);
        chk_state("rst_state", S_HOLD);
        chk_outs("rst_force2", O_HOLD);
        chk_cnt("rst_cnt", 32'd0, 32'd0);

        // Exactly two HOLD cycles after release; branch/halt ignored there.
        drive(0, 1, 1, 1, 1, 0);
        chk_state("hold1", S_HOLD);
        chk_outs("hold1", O_HOLD);
        drive(0, 0, 0, 0, 0, 0);
        chk_state("hold2", S_HOLD);
        chk_outs("hold2", O_HOLD);
        drive(0, 0, 0, 0, 0, 0);
        chk_state("run1", S_RUN);
        chk_outs("run1", O_NORM);
        chk_cnt("hold_cnt", 32'd0, 32'd0);

        // Load-use: one cycle, then two back-to-back.
        drive(0, 1, 0, 0, 0, 0);
        chk_outs("stall_a", O_STALL);
        drive(0, 0, 0, 0, 0, 0);
        chk_outs("stall_a_end", O_NORM);
        chk_cnt("stall_a", 32'd1, 32'd0);
        drive(0, 1, 0, 0, 0, 0);
        chk_outs("stall_b1", O_STALL);
        drive(0, 1, 0, 0, 0, 0);
        chk_outs("stall_b2", O_STALL);
        chk_cnt("stall_b2", 32'd2, 32'd0);
        drive(0, 0, 0, 0, 0, 0);
        chk_cnt("stall_b", 32'd3, 32'd0);
        chk_state("stall_b", S_RUN);

        // BR wins over BrTaken, then BrTaken alone.
        drive(0, 0, 1, 1, 0, 0);
        chk_outs("br_both", O_BR);
        drive(0, 0, 1, 0, 0, 0);
        chk_outs("br_taken", O_BTAKEN);
        chk_cnt("br_both", 32'd3, 32'd1);
        drive(0, 0, 0, 0, 0, 0);
        chk_outs("br_after", O_NORM);
        chk_cnt("br_after", 32'd3, 32'd2);

        // Branch with load-use is deferred to the next hazard-free cycle.
        drive(0, 1, 1, 0, 0, 0);
        chk_outs("luh_br", O_STALL);
        drive(0, 0, 1, 0, 0, 0);
        chk_outs("luh_br_late", O_BTAKEN);
        chk_cnt("luh_br", 32'd4, 32'd2);
        drive(0, 0, 0, 0, 0, 0);
        chk_cnt("luh_br_after", 32'd4, 32'd3);

        // Halt waits behind a stall and behind a branch.
        drive(0, 1, 0, 0, 1, 0);
        chk_outs("halt_stall", O_STALL);
        drive(0, 0, 1, 0, 1, 0);
        chk_state("halt_wait", S_RUN);
        chk_outs("halt_br", O_BTAKEN);
        drive(0, 0, 0, 0, 0, 0);
        chk_state("halt_br_wait", S_RUN);
        chk_cnt("halt_wait", 32'd5, 32'd4);

        // Halt, ignored resume-with-halt, then valid resume.
        drive(0, 0, 0, 0, 1, 0);
        chk_outs("halt_req", O_HALT);
        drive(0, 1, 1, 1, 1, 1);
        chk_state("halted1", S_HALTED);
        chk_outs("halted1", O_HALT);
        drive(0, 0, 0, 0, 0, 1);
        chk_state("halted2", S_HALTED);
        chk_outs("resume_cyc", O_HALT);
        chk_cnt("halted_frozen", 32'd5, 32'd4);
        drive(0, 0, 0, 0, 0, 0);
        chk_state("resumed", S_RUN);
        chk_outs("resumed", O_NORM);

        // Stall counter saturation from a preloaded value.
        @(negedge clk);
        force dut.stall_cnt_q = 32'hFFFF_FFFE;
        @(negedge clk);
        release dut.stall_cnt_q;
        #1;
        chk_cnt("preload", 32'hFFFF_FFFE, 32'd4);
        drive(0, 1, 0, 0, 0, 0);
        chk_outs("sat1", O_STALL);
        drive(0, 1, 0, 0, 0, 0);
        chk_cnt("sat1", 32'hFFFF_FFFF, 32'd4);
        drive(0, 1, 0, 0, 0, 0);
        chk_cnt("sat2", 32'hFFFF_FFFF, 32'd4);

        // Reset mid-stall: outputs forced immediately, everything cleared.
        drive(1, 1, 0, 0, 0, 0);
        chk_outs("rst_mid", O_HOLD);
        chk_cnt("sat3", 32'hFFFF_FFFF, 32'd4);
        drive(0, 0, 0, 0, 0, 0);
        chk_state("rst_mid", S_HOLD);
        chk_cnt("rst_mid", 32'd0, 32'd0);
        chk_outs("rehold1", O_HOLD);
        drive(0, 0, 0, 0, 0, 0);
        chk_state("rehold2", S_HOLD);
        drive(0, 0, 0, 0, 0, 0);
        chk_state("rerun", S_RUN);
        chk_outs("rerun", O_NORM);

        // Reset while HALTED.
        drive(0, 0, 0, 0, 1, 0);
        drive(0, 0, 0, 0, 1, 0);
        chk_state("halt_again", S_HALTED);
        drive(1, 0, 0, 0, 1, 0);
        chk_outs("rst_halted", O_HOLD);
        drive(0, 0, 0, 0, 0, 0);
        chk_state("rst_halted", S_HOLD);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

    // Guard against a stuck run.
    initial begin
        #20000;
        $display("FAIL timeout: observed no completion expected finish");
        $fatal(1, "timeout");
    end

endmodule
